// File: rtl/pzvbus_slave_buffer_if.sv
// Valid-only pzvbus link: the master drives valid/payload every cycle, the slave cannot stall it.
// No ready signal exists; receivers must either keep up or account for beats with credits.
interface pzvbus_if #(
    parameter type PAYLOAD = logic [7:0]
) ();
    logic   valid;
    PAYLOAD payload;

    modport master (output valid, output payload);
    modport slave  (input  valid, input  payload);
endinterface

// File: rtl/pzvbus_slave_buffer.sv
// pzvbus receive terminator: DEPTH-entry FIFO re-issued as valid/ready, 1-cycle fill latency, registered credit per pop.
// Input cannot be stalled: beats arriving while full with no pop are dropped and flagged in a sticky overflow bit.
module pzvbus_slave_buffer #(
    parameter type PAYLOAD     = logic [7:0],
    parameter int  DEPTH       = 4,
    parameter int  COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    pzvbus_if.slave                slave_if,
    output logic                   o_valid,
    input  logic                   i_ready,
    output PAYLOAD                 o_payload,
    output logic                   o_credit,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_overflow,
    input  logic                   i_clear_overflow
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    PAYLOAD                 r_mem [DEPTH];
    ptr_t                   r_wr_ptr;
    ptr_t                   r_rd_ptr;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_credit;
    logic                   r_overflow;

    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic ptr_t f_next_ptr(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        w_full = (r_count == COUNT_WIDTH'(DEPTH));
        w_pop  = o_valid && i_ready;
        w_push = slave_if.valid && (!w_full || w_pop);
        w_drop = slave_if.valid && !w_push;
    end

    // Storage is deliberately not reset; the head is only meaningful while o_valid=1.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= slave_if.payload;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_WIDTH'(1);
                2'b01:   r_count <= r_count - COUNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set so no loss goes unreported.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_credit <= w_pop;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_valid    = (r_count != '0);
    assign o_payload  = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_credit   = r_credit;
    assign o_overflow = r_overflow;

    a_count_bound: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        r_count <= COUNT_WIDTH'(DEPTH)
    );

    a_stall_stable: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (o_valid && !i_ready) |=> $stable(o_payload)
    );

endmodule

// File: tb/tb_pzvbus_slave_buffer.sv
// Bench for pzvbus_slave_buffer: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_pzvbus_slave_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          rdy;
    logic          clr;
    logic          o_valid;
    logic [7:0]    o_payload;
    logic          o_credit;
    logic [CW-1:0] o_count;
    logic          o_overflow;

    pzvbus_if #(.PAYLOAD(logic [7:0])) bus ();

    pzvbus_slave_buffer #(
        .PAYLOAD (logic [7:0]),
        .DEPTH   (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .slave_if         (bus),
        .o_valid          (o_valid),
        .i_ready          (rdy),
        .o_payload        (o_payload),
        .o_credit         (o_credit),
        .o_count          (o_count),
        .o_overflow       (o_overflow),
        .i_clear_overflow (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue with the occupancy/credit/overflow rules.
    logic [7:0] mq[$];
    bit         m_cred;
    bit         m_ovf;
    bit         m_pop;
    bit         m_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cred = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_pop  = (mq.size() != 0) && rdy;
            m_push = bus.valid && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(bus.payload);
            m_cred = m_pop;
            if (bus.valid && !m_push) m_ovf = 1'b1;
            else if (clr)             m_ovf = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input bit v, input logic [7:0] p, input bit r, input bit c);
        bus.valid   = v;
        bus.payload = p;
        rdy         = r;
        clr         = c;
        tick();
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_valid"},  int'(o_valid),    int'(mq.size() != 0));
        chk({tag, "_count"},  int'(o_count),    mq.size());
        chk({tag, "_credit"}, int'(o_credit),   int'(m_cred));
        chk({tag, "_ovf"},    int'(o_overflow), int'(m_ovf));
        if (mq.size() != 0) chk({tag, "_payload"}, int'(o_payload), int'(mq[0]));
    endtask

    typedef struct {
        bit         vld;
        logic [7:0] pay;
        bit         rdy;
        bit         clr;
        bit         e_vld;
        logic [7:0] e_pay;
        int         e_cnt;
        bit         e_cred;
        bit         e_ovf;
    } vec_t;

    vec_t tbl[$];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] rx[$];
        logic [7:0] held;
        int         sent;
        int         creds;
        int         credit_total;
        bit         done;
        bit         stalled;

        // Expected outputs after each edge: 3-beat passthrough, fill/drop, full+pop, drain, clear.
        tbl.push_back(vec_t'{1, 8'h11, 1, 0,  1, 8'h11, 1, 0, 0});
        tbl.push_back(vec_t'{1, 8'h22, 1, 0,  1, 8'h22, 1, 1, 0});
        tbl.push_back(vec_t'{1, 8'h33, 1, 0,  1, 8'h33, 1, 1, 0});
        tbl.push_back(vec_t'{0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 0});
        tbl.push_back(vec_t'{0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0});
        tbl.push_back(vec_t'{1, 8'hA0, 0, 0,  1, 8'hA0, 1, 0, 0});
        tbl.push_back(vec_t'{1, 8'hA1, 0, 0,  1, 8'hA0, 2, 0, 0});
        tbl.push_back(vec_t'{1, 8'hA2, 0, 0,  1, 8'hA0, 3, 0, 0});
        tbl.push_back(vec_t'{1, 8'hA3, 0, 0,  1, 8'hA0, 4, 0, 0});
        tbl.push_back(vec_t'{1, 8'hA4, 0, 0,  1, 8'hA0, 4, 0, 1});
        tbl.push_back(vec_t'{1, 8'hB5, 1, 0,  1, 8'hA1, 4, 1, 1});
        tbl.push_back(vec_t'{0, 8'h00, 1, 0,  1, 8'hA2, 3, 1, 1});
        tbl.push_back(vec_t'{0, 8'h00, 1, 0,  1, 8'hA3, 2, 1, 1});
        tbl.push_back(vec_t'{0, 8'h00, 1, 0,  1, 8'hB5, 1, 1, 1});
        tbl.push_back(vec_t'{0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 1});
        tbl.push_back(vec_t'{0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 1});
        tbl.push_back(vec_t'{0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0});

        rst_n       = 1'b0;
        bus.valid   = 1'b0;
        bus.payload = 8'h00;
        rdy         = 1'b0;
        clr         = 1'b0;
        #12;
        chk("reset_valid",  int'(o_valid),    0);
        chk("reset_count",  int'(o_count),    0);
        chk("reset_credit", int'(o_credit),   0);
        chk("reset_ovf",    int'(o_overflow), 0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].vld, tbl[i].pay, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("vec%0d_valid", i),  int'(o_valid),    int'(tbl[i].e_vld));
            chk($sformatf("vec%0d_count", i),  int'(o_count),    tbl[i].e_cnt);
            chk($sformatf("vec%0d_credit", i), int'(o_credit),   int'(tbl[i].e_cred));
            chk($sformatf("vec%0d_ovf", i),    int'(o_overflow), int'(tbl[i].e_ovf));
            if (tbl[i].e_vld) chk($sformatf("vec%0d_payload", i), int'(o_payload), int'(tbl[i].e_pay));
        end

        // Drop coinciding with clear: set wins; clear alone then takes effect.
        for (int i = 0; i < DEPTH; i++) apply(1, 8'hC0 + 8'(i), 0, 0);
        apply(1, 8'hCE, 0, 0);
        chk("ovf_set", int'(o_overflow), 1);
        apply(1, 8'hCF, 0, 1);
        chk("ovf_set_wins", int'(o_overflow), 1);
        chk("ovf_fifo_unchanged", int'(o_payload), 8'hC0);
        apply(0, 8'h00, 0, 1);
        chk("ovf_clear", int'(o_overflow), 0);
        for (int i = 0; i < DEPTH + 1; i++) apply(0, 8'h00, 1, 0);
        chk("ovf_drained", int'(o_count), 0);

        // Credit-compliant master streaming 0..9 against a toggling ready.
        sent = 0; creds = DEPTH; credit_total = 0; done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            bus.valid   = (sent < 10) && (creds > 0);
            bus.payload = 8'(sent);
            rdy         = (cyc % 2 == 0);
            clr         = 1'b0;
            stalled     = o_valid && !rdy;
            held        = o_payload;
            if (o_valid && rdy) rx.push_back(o_payload);
            if (bus.valid) begin
                sent++;
                creds--;
            end
            tick();
            if (stalled) chk("stall_stable", int'(o_payload), int'(held));
            if (o_credit) begin
                creds++;
                credit_total++;
            end
            done = (rx.size() == 10) && (o_count == 0) && !o_credit;
        end
        chk("stream_done", int'(done), 1);
        chk("stream_rx_count", rx.size(), 10);
        for (int i = 0; i < rx.size(); i++) chk($sformatf("stream_order%0d", i), int'(rx[i]), i);
        chk("stream_credits", credit_total, 10);
        chk("stream_no_ovf", int'(o_overflow), 0);

        // Randomized traffic against the reference model, with varying ready bias.
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 3) < ((i / 100) + 1), $urandom_range(0, 15) == 0);
            chk_model("rand");
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            apply(0, 8'h00, 1, 1);
            chk_model("rdrain");
        end

        // Asynchronous reset mid-cycle with three entries held and a credit outstanding.
        for (int i = 0; i < DEPTH; i++) apply(1, 8'hD0 + 8'(i), 0, 0);
        apply(1, 8'hDF, 0, 0);
        apply(0, 8'h00, 1, 0);
        chk("prerst_count",  int'(o_count),    3);
        chk("prerst_credit", int'(o_credit),   1);
        chk("prerst_ovf",    int'(o_overflow), 1);
        rdy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid",  int'(o_valid),    0);
        chk("midrst_count",  int'(o_count),    0);
        chk("midrst_credit", int'(o_credit),   0);
        chk("midrst_ovf",    int'(o_overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 8'h5A, 0, 0);
        chk("postrst_valid",   int'(o_valid),   1);
        chk("postrst_payload", int'(o_payload), 8'h5A);
        chk("postrst_count",   int'(o_count),   1);
        apply(0, 8'h00, 1, 0);
        chk("postrst_pop_count",  int'(o_count),  0);
        chk("postrst_pop_credit", int'(o_credit), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
